// File: rtl/mem_lsu16_if.sv
// CPU/BRAM bus for mem_lsu16. The slave modport is the load/store unit's view;
// the master modport is the view of its environment (CPU request side plus the
// BRAM data return).
// Optional feature macro: MEM_LSU16_SIGN_EXT_EN adds the sext request field.
interface mem_lsu16_if;
  logic        req;
  logic        we;
  logic        size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [15:0] ram_a;
  logic [15:0] ram_do;
  logic        ram_we;
  logic [15:0] ram_di;
`ifdef MEM_LSU16_SIGN_EXT_EN
  logic        sext;

  modport slave (
    input  req, we, size, addr, wdata, sext, ram_di,
    output rdata, ack, err, busy, ram_a, ram_do, ram_we
  );
  modport master (
    output req, we, size, addr, wdata, sext, ram_di,
    input  rdata, ack, err, busy, ram_a, ram_do, ram_we
  );
`else
  modport slave (
    input  req, we, size, addr, wdata, ram_di,
    output rdata, ack, err, busy, ram_a, ram_do, ram_we
  );
  modport master (
    output req, we, size, addr, wdata, ram_di,
    input  rdata, ack, err, busy, ram_a, ram_do, ram_we
  );
`endif
endinterface

// File: rtl/mem_lsu16.sv
// mem_lsu16: byte/word load-store unit in front of a 16-bit synchronous BRAM
// (1-cycle read latency, no byte enables). Byte stores are read-modify-write.
// Misaligned word accesses and addresses above adr_width bits are rejected
// without a BRAM write.
// Optional feature macro: MEM_LSU16_SIGN_EXT_EN (sign-extending byte loads).
module mem_lsu16 #(
  parameter int adr_width = 11
) (
  input logic         sys_clk,
  input logic         sys_rst,
  mem_lsu16_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;

  state_t      state_q;
  logic        we_q;
  logic        size_q;
  logic        lane_q;       // addr[0] of the accepted request
  logic [7:0]  wbyte_q;      // wdata[7:0] of the accepted request
  logic        sext_q;
  logic [15:0] rdata_q;
  logic [15:0] ram_a_q;
  logic [15:0] ram_do_q;
  logic        ram_we_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;

  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rdata_d;
  logic [15:0] ram_do_d;

  // Request check, load extraction and byte-store merge from current inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_err  = 1'b0;
    rd_byte  = 8'h00;
    rdata_d  = 16'h0000;
    ram_do_d = 16'h0000;

    req_err  = (bus.size & bus.addr[0]) | ((bus.addr >> adr_width) != 16'd0);
    rd_byte  = lane_q ? bus.ram_di[15:8] : bus.ram_di[7:0];
    rdata_d  = size_q ? bus.ram_di : {{8{sext_q & rd_byte[7]}}, rd_byte};
    ram_do_d = lane_q ? {wbyte_q, bus.ram_di[7:0]} : {bus.ram_di[15:8], wbyte_q};
  end

`ifndef MEM_LSU16_SIGN_EXT_EN
  assign sext_q = 1'b0;
`endif

  // Access FSM with registered outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (sys_rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 1'b0;
      lane_q   <= 1'b0;
      wbyte_q  <= 8'h00;
`ifdef MEM_LSU16_SIGN_EXT_EN
      sext_q   <= 1'b0;
`endif
      rdata_q  <= 16'h0000;
      ram_a_q  <= 16'h0000;
      ram_do_q <= 16'h0000;
      ram_we_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            lane_q  <= bus.addr[0];
            wbyte_q <= bus.wdata[7:0];
`ifdef MEM_LSU16_SIGN_EXT_EN
            sext_q  <= bus.sext;
`endif
            ram_a_q <= {bus.addr[15:1], 1'b0};
            busy_q  <= 1'b1;
            if (req_err) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 16'h0000;
            end else if (bus.we && bus.size) begin
              state_q  <= WR;
              ram_we_q <= 1'b1;
              ram_do_q <= bus.wdata;
            end else begin
              state_q <= RD_ADDR;
            end
          end
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          if (we_q) begin
            // Byte store: the read word with one lane replaced goes back out.
            ram_do_q <= ram_do_d;
            ram_we_q <= 1'b1;
            state_q  <= WR;
          end else begin
            rdata_q <= rdata_d;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        WR: begin
          ack_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.ram_a  = ram_a_q;
  assign bus.ram_do = ram_do_q;
  assign bus.ram_we = ram_we_q;

endmodule

// File: tb/tb_mem_lsu16.sv
// Bench for mem_lsu16: directed accesses against a behavioural BRAM, with a
// scoreboard queue of expected responses filled when a request is driven and
// drained when ack appears. Build with MEM_LSU16_SIGN_EXT_EN to cover sext.
module tb_mem_lsu16;

  localparam int ADR_W = 11;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  logic sys_clk;
  logic sys_rst;
  mem_lsu16_if bus ();

  mem_lsu16 #(.adr_width(ADR_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          ack_cnt = 0;
  logic [15:0] wr_a;
  logic [15:0] wr_do;
  logic [15:0] tb_rdata = 16'h0000;
  logic [15:0] mem [0:(1 << (ADR_W - 1)) - 1];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural BRAM: word-wide write, registered read.
  always @(posedge sys_clk) begin
    if (bus.ram_we) mem[bus.ram_a[ADR_W-1:1]] <= bus.ram_do;
    bus.ram_di <= mem[bus.ram_a[ADR_W-1:1]];
  end

  // Bus monitor sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (bus.ram_we) begin
      wr_cnt = wr_cnt + 1;
      wr_a   = bus.ram_a;
      wr_do  = bus.ram_do;
    end
    if (bus.ack) ack_cnt = ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access from an IDLE-aligned point (#1 after an edge) through RESP->IDLE.
  task automatic access(input string tag, input bit we_v, input bit size_v, input bit sext_v,
                        input logic [15:0] a, input logic [15:0] d, input int lat,
                        input bit err_v, input logic [15:0] rd_exp, input logic [15:0] wr_exp,
                        input bit mutate);
    exp_t e;
    int   cyc;
    int   wr0;
    bit   seen;
    e.err   = err_v;
    e.lat   = lat;
    e.rdata = err_v ? 16'h0000 : (we_v ? tb_rdata : rd_exp);
    tb_rdata = e.rdata;
    sb_q.push_back(e);
    wr0 = wr_cnt;
    bus.req   = 1'b1;
    bus.we    = we_v;
    bus.size  = size_v;
    bus.addr  = a;
    bus.wdata = d;
`ifdef MEM_LSU16_SIGN_EXT_EN
    bus.sext  = sext_v;
`endif
    @(posedge sys_clk);
    #1;
    if (mutate) begin
      bus.addr  = ~a;
      bus.wdata = ~d;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge sys_clk);
      if (bus.ack) seen = 1'b1;
      else cyc++;
    end
    bus.req = 1'b0;
    check({tag, "_ack_seen"}, seen, 1);
    if (seen && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, cyc, e.lat);
      check({tag, "_busy"}, bus.busy, 1);
      check({tag, "_err"}, bus.err, e.err);
      check({tag, "_rdata"}, bus.rdata, e.rdata);
    end
    check({tag, "_writes"}, wr_cnt - wr0, (we_v && !err_v) ? 1 : 0);
    if (we_v && !err_v) begin
      check({tag, "_wr_addr"}, wr_a, {a[15:1], 1'b0});
      check({tag, "_wr_data"}, wr_do, wr_exp);
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int          wr0;
    int          ack0;
    logic [11:0] ack_pat;
    logic [11:0] busy_pat;
    exp_t        e;

    sys_rst   = 1'b1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 16'h0000;
`ifdef MEM_LSU16_SIGN_EXT_EN
    bus.sext  = 1'b0;
`endif
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_a", bus.ram_a, 0);
    check("rst_ram_do", bus.ram_do, 0);
    @(posedge sys_clk);
    #1;

    // Word store / word load.
    access("wst_beef", 1, 1, 0, 16'h0010, 16'hBEEF, 1, 0, 16'h0000, 16'hBEEF, 0);
    access("wld_beef", 0, 1, 0, 16'h0010, 16'h0000, 2, 0, 16'hBEEF, 16'h0000, 0);

    // Byte store into the upper lane, then both byte lanes back.
    access("bst_12", 1, 0, 0, 16'h0011, 16'hA512, 3, 0, 16'h0000, 16'h12EF, 0);
    access("bld_lo", 0, 0, 0, 16'h0010, 16'h0000, 2, 0, 16'h00EF, 16'h0000, 0);
    access("bld_hi", 0, 0, 0, 16'h0011, 16'h0000, 2, 0, 16'h0012, 16'h0000, 0);

    // Rejected accesses: misaligned word load, out-of-range word store.
    access("err_misalign", 0, 1, 0, 16'h0013, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0);
    access("err_range", 1, 1, 0, 16'h0800, 16'h5555, 0, 1, 16'h0000, 16'h0000, 0);

    // Byte 9C into the upper lane, then zero/sign-extending loads.
    access("bst_9c", 1, 0, 0, 16'h0011, 16'h009C, 3, 0, 16'h0000, 16'h9CEF, 0);
`ifdef MEM_LSU16_SIGN_EXT_EN
    access("bld_sext1", 0, 0, 1, 16'h0011, 16'h0000, 2, 0, 16'hFF9C, 16'h0000, 0);
`endif
    access("bld_sext0", 0, 0, 0, 16'h0011, 16'h0000, 2, 0, 16'h009C, 16'h0000, 0);

    // Inputs changed right after acceptance must not affect the access.
    access("latch_st", 1, 1, 0, 16'h0020, 16'h1234, 1, 0, 16'h0000, 16'h1234, 1);
    access("latch_ld", 0, 1, 0, 16'h0020, 16'h0000, 2, 0, 16'h1234, 16'h0000, 1);

    // req held high: one access every four cycles with an IDLE cycle between.
    repeat (3) begin
      e.err = 1'b0; e.rdata = 16'h9CEF; e.lat = 2;
      sb_q.push_back(e);
    end
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.size = 1'b1;
    bus.addr = 16'h0010;
    ack_pat  = '0;
    busy_pat = '0;
    @(posedge sys_clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      ack_pat[k]  = bus.ack;
      busy_pat[k] = bus.busy;
      if (bus.ack && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("bb_rdata", bus.rdata, e.rdata);
      end
    end
    bus.req = 1'b0;
    tb_rdata = 16'h9CEF;
    check("bb_ack_pattern", ack_pat, 12'h444);
    check("bb_busy_pattern", busy_pat, 12'h777);
    repeat (2) @(posedge sys_clk);
    #1;
    check("bb_idle", bus.busy, 0);

    // Reset while a byte store to 0x0010 sits in RD_DATA.
    wr0  = wr_cnt;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.size  = 1'b0;
    bus.addr  = 16'h0010;
    bus.wdata = 16'h00AA;
    @(posedge sys_clk);
    #1;
    bus.req = 1'b0;
    @(posedge sys_clk);
    #1;
    check("abort_busy_before", bus.busy, 1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    ack0 = ack_cnt;
    @(negedge sys_clk);
    check("abort_busy_after", bus.busy, 0);
    check("abort_rdata", bus.rdata, 0);
    repeat (4) @(negedge sys_clk);
    check("abort_no_ack", ack_cnt - ack0, 0);
    check("abort_no_write", wr_cnt - wr0, 0);
    @(posedge sys_clk);
    #1;
    tb_rdata = 16'h0000;
    access("abort_reload", 0, 1, 0, 16'h0010, 16'h0000, 2, 0, 16'h9CEF, 16'h0000, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu16.md
Name: mem_lsu16

Overview:
- Load/store unit that sits directly upstream of the 16-bit synchronous data BRAM (1-cycle read latency, word-wide write enable, byte address).
- Accepts byte and word load/store requests from the CPU over a req/ack handshake and drives the BRAM port.
- Byte stores are implemented as read-modify-write, because the BRAM has no byte enables.
- Misaligned word accesses and out-of-range addresses are flagged as errors and never reach the BRAM.

Parameters:
adr_width, 11, byte-address width decoded by the BRAM; addr[15:adr_width] must be zero.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous, active-high reset
req  in  1  CPU request; held high until ack
we  in  1  1=store, 0=load
size  in  1  1=word, 0=byte
addr  in  16  byte address
wdata  in  16  store data; byte stores use wdata[7:0]
rdata  out  16  load data; valid only while ack=1
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack; 1=access rejected
busy  out  1  high in every state except IDLE
ram_a  out  16  BRAM byte address
ram_do  out  16  BRAM write data
ram_we  out  1  BRAM write enable
ram_di  in  16  BRAM read data; valid the cycle after ram_a is presented

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - rdata, ram_a and ram_do go to 0; ack, err, busy and ram_we go to 0.
  - Reset mid-operation aborts the access: no ack is produced, and no ram_we occurs after the reset edge.
  - A byte store aborted before WR leaves memory unchanged.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- Acceptance:
  - A request is accepted only in IDLE, at an edge where req=1.
  - we, size, addr and wdata are latched at acceptance; later changes have no effect.
  - req is ignored in every other state.
- Error check at acceptance:
  - err = (size & addr[0]) | (addr[15:adr_width] != 0).
  - On error the next state is RESP with ack=1 and err=1; rdata=0; no BRAM access occurs.
- ram_a:
  - Driven as {addr[15:1],1'b0} from the latched address in all non-IDLE states.
  - Holds its last value in IDLE.
- Byte lanes (little-endian): addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
- Transitions, with acceptance at edge N:
  - Word store: IDLE -> WR. WR drives ram_we=1 and ram_do=wdata. Edge N+1 performs the write and moves to RESP. ack is high for the cycle after N+1.
  - Word load: IDLE -> RD_ADDR -> RD_DATA. At edge N+2, rdata <= ram_di and the state moves to RESP. ack is high for the cycle after N+2.
  - Byte load: same timing as a word load. rdata = {8'h00, selected byte}.
  - Byte store: IDLE -> RD_ADDR -> RD_DATA. At edge N+2, the merge buffer takes ram_di with the selected lane replaced by wdata[7:0], and the state moves to WR. WR drives ram_we=1 and ram_do=merged data. Edge N+3 writes. ack is high for the cycle after N+3.
- RESP:
  - ack=1 for exactly one cycle, then IDLE.
  - The earliest next acceptance is the edge ending the first IDLE cycle, so there is one idle cycle between accesses.
- ram_we:
  - Is 1 only in WR, and for exactly one cycle per store.
  - ram_do is stable whenever ram_we=1.
- rdata holds its value until the next load completes; it is cleared to 0 on an error response.
- Store responses leave rdata unchanged.

Optional Feature:
- Macro: MEM_LSU16_SIGN_EXT_EN.
- Defined:
  - Adds input port sext (1 bit), latched at acceptance.
  - A byte load with sext=1 returns {{8{byte[7]}}, byte}.
  - A byte load with sext=0, and any word access, behaves as in Behaviour.
- Undefined:
  - The sext port does not exist.
  - Byte loads always zero-extend.

Test Plan:
- Word store 16'hBEEF to addr 16'h0010, then word load from 16'h0010:
  - Store: ram_we high exactly one cycle, with ram_a=16'h0010 and ram_do=16'hBEEF; ack at N+1 with err=0.
  - Load: ack at N+2 with rdata=16'hBEEF.
- Byte store 8'h12 to 16'h0011 over a word holding 16'hBEEF:
  - Write happens at N+3 with ram_do=16'h12EF.
  - A byte load from 16'h0010 then returns 16'h00EF.
  - A byte load from 16'h0011 returns 16'h0012.
- Byte load of 16'h0011 holding 8'h9C:
  - With MEM_LSU16_SIGN_EXT_EN and sext=1: rdata=16'hFF9C.
  - With sext=0, or with the macro undefined: rdata=16'h009C.
- Error responses with adr_width=11:
  - Word load from 16'h0013 (misaligned): ack and err=1 one cycle after acceptance, rdata=0, ram_we never asserted.
  - Word store to 16'h0800 (out of range): same response as the misaligned load.
- Handshake:
  - Change addr and wdata while busy=1: the access completes on the originally latched values.
  - Keep req=1 continuously: exactly one access per ack, with one IDLE cycle between accesses.
- Assert sys_rst in the RD_DATA state of a byte store to 16'h0010:
  - No ack and no ram_we afterwards; busy=0 after the reset edge.
  - A subsequent word load of 16'h0010 returns the original contents.
